// File: rtl/rv32imf_pkg.sv
// Shared APU interface constants and types for the RV32IMF core/FPU boundary.
package rv32imf_pkg;

  localparam int APU_NARGS    = 3;
  localparam int APU_WOP      = 6;
  localparam int APU_NDSFLAGS = 15;
  localparam int APU_NUSFLAGS = 5;

  typedef enum logic [1:0] {
    LAT_ADDMUL  = 2'd0,
    LAT_DIVSQRT = 2'd1,
    LAT_NONCOMP = 2'd2,
    LAT_CONV    = 2'd3
  } apu_lat_e;

  typedef struct packed {
    logic [APU_NARGS-1:0][31:0] operands;
    logic [APU_WOP-1:0]         op;
    logic [APU_NDSFLAGS-1:0]    flags;
  } apu_payload_t;

endpackage

// File: rtl/rv32imf_apu_tag_fifo.sv
// In-order FIFO of in-flight destination registers; per-slot valid bits feed the hazard compare.
module rv32imf_apu_tag_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_addr_i,
  input  logic                         pop_i,
  output logic [ADDR_W-1:0]            head_addr_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] tags_o,
  output logic [DEPTH-1:0]             valid_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]               count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] tags_q;

  // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    if (pop_i) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PTR_W'(1);
    end
    if (push_i) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PTR_W'(1);
    end
    count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: tag storage is deliberately unreset; valid_q alone qualifies every slot.
  always_ff @(posedge clk_i) begin
    if (push_i) tags_q[wptr_q] <= push_addr_i;
  end

  assign head_addr_o = tags_q[rptr_q];
  assign count_o     = count_q;
  assign tags_o      = tags_q;
  assign valid_o     = valid_q;

endmodule

// File: rtl/rv32imf_apu_disp.sv
// Core-side APU initiator: holds the request payload until granted, tracks in-flight
// destinations in issue order, and turns FPU results into register-file writebacks.
module rv32imf_apu_disp
  import rv32imf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [APU_NARGS-1:0][31:0]      issue_operands_i,
  input  logic [APU_WOP-1:0]              issue_op_i,
  input  logic [APU_NDSFLAGS-1:0]         issue_flags_i,
  input  logic [1:0]                      issue_lat_i,
  input  logic [ADDR_W-1:0]               issue_waddr_i,
  output logic                            apu_req_o,
  input  logic                            apu_gnt_i,
  output logic [APU_NARGS-1:0][31:0]      apu_operands_o,
  output logic [APU_WOP-1:0]              apu_op_o,
  output logic [APU_NDSFLAGS-1:0]         apu_flags_o,
  input  logic                            apu_rvalid_i,
  input  logic [31:0]                     apu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]         apu_rflags_i,
  output logic                            wb_valid_o,
  output logic [ADDR_W-1:0]               wb_waddr_o,
  output logic [31:0]                     wb_wdata_o,
  output logic [APU_NUSFLAGS-1:0]         fflags_o,
  input  logic                            fflags_clr_i,
  input  logic [APU_NARGS-1:0][ADDR_W-1:0] hazard_raddr_i,
  output logic                            hazard_o,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         req_q, req_d;
  apu_payload_t                 pay_q, pay_d;
  apu_lat_e                     lat_q, lat_d;
  logic                         wb_valid_q;
  logic [ADDR_W-1:0]            wb_waddr_q;
  logic [31:0]                  wb_wdata_q;
  logic [APU_NUSFLAGS-1:0]      fflags_q, fflags_d;
  logic                         err_q;

  logic [CNT_W-1:0]             count;
  logic [ADDR_W-1:0]            head_addr;
  logic [DEPTH-1:0][ADDR_W-1:0] tags;
  logic [DEPTH-1:0]             valid;
  logic                         lat_ok, accept, pop, hazard;

  // Mixing latency classes would reorder results, so a class change waits for an empty FIFO.
  assign lat_ok        = (count == '0) || (apu_lat_e'(issue_lat_i) == lat_q);
  assign issue_ready_o = (!req_q || apu_gnt_i) && (count < CNT_W'(DEPTH)) && lat_ok;
  assign accept        = issue_valid_i && issue_ready_o;
  assign pop           = apu_rvalid_i && (count != '0);

  rv32imf_apu_tag_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_addr_i (issue_waddr_i),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .count_o     (count),
    .tags_o      (tags),
    .valid_o     (valid)
  );

  always_comb begin
    req_d = req_q;
    pay_d = pay_q;
    lat_d = lat_q;
    if (accept) begin
      req_d = 1'b1;
      pay_d = '{operands: issue_operands_i, op: issue_op_i, flags: issue_flags_i};
      lat_d = apu_lat_e'(issue_lat_i);
    end else if (req_q && apu_gnt_i) begin
      req_d = 1'b0;
    end
    fflags_d = (fflags_clr_i ? '0 : fflags_q) | (pop ? apu_rflags_i : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      pay_q      <= '0;
      lat_q      <= LAT_ADDMUL;
      wb_valid_q <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      fflags_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      req_q      <= req_d;
      pay_q      <= pay_d;
      lat_q      <= lat_d;
      wb_valid_q <= pop;
      if (pop) begin
        wb_waddr_q <= head_addr;
        wb_wdata_q <= apu_rdata_i;
      end
      fflags_q <= fflags_d;
      if (apu_rvalid_i && (count == '0)) err_q <= 1'b1;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < APU_NARGS; s++) begin
      if (wb_valid_q && (wb_waddr_q == hazard_raddr_i[s])) hazard = 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        if (valid[e] && (tags[e] == hazard_raddr_i[s])) hazard = 1'b1;
      end
    end
  end

  assign apu_req_o      = req_q;
  assign apu_operands_o = pay_q.operands;
  assign apu_op_o       = pay_q.op;
  assign apu_flags_o    = pay_q.flags;
  assign wb_valid_o     = wb_valid_q;
  assign wb_waddr_o     = wb_waddr_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign fflags_o       = fflags_q;
  assign hazard_o       = hazard;
  assign busy_o         = req_q || (count != '0) || wb_valid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_rv32imf_apu_disp.sv
// Scoreboard bench for rv32imf_apu_disp: stimulus queues expected grants and writebacks,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_rv32imf_apu_disp;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              issue_valid_i = 1'b0;
  logic              issue_ready_o;
  logic [2:0][31:0]  issue_operands_i = '0;
  logic [5:0]        issue_op_i = '0;
  logic [14:0]       issue_flags_i = '0;
  logic [1:0]        issue_lat_i = '0;
  logic [5:0]        issue_waddr_i = '0;
  logic              apu_req_o;
  logic              apu_gnt_i = 1'b1;
  logic [2:0][31:0]  apu_operands_o;
  logic [5:0]        apu_op_o;
  logic [14:0]       apu_flags_o;
  logic              apu_rvalid_i = 1'b0;
  logic [31:0]       apu_rdata_i = '0;
  logic [4:0]        apu_rflags_i = '0;
  logic              wb_valid_o;
  logic [5:0]        wb_waddr_o;
  logic [31:0]       wb_wdata_o;
  logic [4:0]        fflags_o;
  logic              fflags_clr_i = 1'b0;
  logic [2:0][5:0]   hazard_raddr_i = '0;
  logic              hazard_o;
  logic              busy_o;
  logic              err_o;

  rv32imf_apu_disp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_operands_i (issue_operands_i),
    .issue_op_i       (issue_op_i),
    .issue_flags_i    (issue_flags_i),
    .issue_lat_i      (issue_lat_i),
    .issue_waddr_i    (issue_waddr_i),
    .apu_req_o        (apu_req_o),
    .apu_gnt_i        (apu_gnt_i),
    .apu_operands_o   (apu_operands_o),
    .apu_op_o         (apu_op_o),
    .apu_flags_o      (apu_flags_o),
    .apu_rvalid_i     (apu_rvalid_i),
    .apu_rdata_i      (apu_rdata_i),
    .apu_rflags_i     (apu_rflags_i),
    .wb_valid_o       (wb_valid_o),
    .wb_waddr_o       (wb_waddr_o),
    .wb_wdata_o       (wb_wdata_o),
    .fflags_o         (fflags_o),
    .fflags_clr_i     (fflags_clr_i),
    .hazard_raddr_i   (hazard_raddr_i),
    .hazard_o         (hazard_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  waddr;
    logic [31:0] data;
  } wb_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [116:0] exp_req[$];
  logic [5:0]   tag_q[$];
  wb_t          exp_wb[$];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Payload is a fixed pattern of the destination address so each request is distinguishable.
  function automatic logic [116:0] payload_of(input logic [5:0] a);
    logic [31:0] o0;
    o0 = {24'hA0B0C0, 2'b00, a};
    return {o0 ^ 32'h5555_5555, ~o0, o0, a ^ 6'h15, a, 9'h0A5};
  endfunction

  function automatic logic [116:0] dut_payload();
    return {apu_operands_o, apu_op_o, apu_flags_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_issue(input logic [5:0] a, input logic [1:0] lat);
    {issue_operands_i, issue_op_i, issue_flags_i} = payload_of(a);
    issue_lat_i   = lat;
    issue_waddr_i = a;
  endtask

  // Holds issue_valid until accepted; waited reports stall cycles before acceptance.
  task automatic do_issue(input logic [5:0] a, input logic [1:0] lat, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    set_issue(a, lat);
    issue_valid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_i);
      if (issue_ready_o) begin
        ok = 1'b1;
        exp_req.push_back(payload_of(a));
        tag_q.push_back(a);
      end else begin
        waited++;
      end
      tick();
    end
    issue_valid_i = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: waddr %0h not accepted within 50 cycles", a);
    end
  endtask

  task automatic respond_begin(input logic [31:0] data, input logic [4:0] flags);
    wb_t e;
    apu_rvalid_i = 1'b1;
    apu_rdata_i  = data;
    apu_rflags_i = flags;
    if (tag_q.size() > 0) begin
      e.waddr = tag_q.pop_front();
      e.data  = data;
      exp_wb.push_back(e);
    end
  endtask

  task automatic respond_end();
    tick();
    apu_rvalid_i = 1'b0;
    apu_rflags_i = '0;
  endtask

  // Monitor: compares every granted request and every writeback against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (apu_req_o && apu_gnt_i) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got op %0h, expected no request", apu_op_o);
        end else begin
          chk_val("req_payload", 128'(dut_payload()), 128'(exp_req.pop_front()));
        end
      end
      if (wb_valid_o) begin
        if (exp_wb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wb_unexpected: got waddr %0h, expected no writeback", wb_waddr_o);
        end else begin
          wb_t e;
          e = exp_wb.pop_front();
          chk_val("wb_waddr", 128'(wb_waddr_o), 128'(e.waddr));
          chk_val("wb_wdata", 128'(wb_wdata_o), 128'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk_bit("rst_req", apu_req_o, 1'b0);
    chk_bit("rst_wb_valid", wb_valid_o, 1'b0);
    chk_val("rst_fflags", 128'(fflags_o), 128'(0));
    chk_bit("rst_busy", busy_o, 1'b0);
    chk_bit("rst_err", err_o, 1'b0);
    chk_bit("rst_hazard", hazard_o, 1'b0);
    chk_val("rst_payload", 128'(dut_payload()), 128'(0));
    rst_ni = 1'b1;
    tick();

    // Single op, grant in the request cycle
    do_issue(6'h21, 2'd0, w);
    @(negedge clk_i);
    chk_bit("single_req_1cyc", apu_req_o, 1'b1);
    tick();
    @(negedge clk_i);
    chk_bit("single_req_drop", apu_req_o, 1'b0);
    tick();
    respond_begin(32'h3F80_0000, 5'h01);
    respond_end();
    @(negedge clk_i);
    chk_bit("single_wb_valid", wb_valid_o, 1'b1);
    chk_val("single_wb_waddr", 128'(wb_waddr_o), 128'(6'h21));
    chk_val("single_fflags", 128'(fflags_o), 128'(5'h01));
    tick();
    @(negedge clk_i);
    chk_bit("single_wb_one_cycle", wb_valid_o, 1'b0);
    tick();

    // Delayed grant: request and payload held for 4 cycles
    apu_gnt_i = 1'b0;
    do_issue(6'h22, 2'd0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk_bit("dly_req_held", apu_req_o, 1'b1);
      chk_val("dly_payload_held", 128'(dut_payload()), 128'(payload_of(6'h22)));
      chk_bit("dly_ready_low", issue_ready_o, 1'b0);
      tick();
    end
    apu_gnt_i = 1'b1;
    @(negedge clk_i);
    chk_bit("dly_req_gnt_cycle", apu_req_o, 1'b1);
    chk_val("dly_payload_gnt_cycle", 128'(dut_payload()), 128'(payload_of(6'h22)));
    chk_bit("dly_ready_gnt_cycle", issue_ready_o, 1'b1);
    tick();
    @(negedge clk_i);
    chk_bit("dly_req_drop", apu_req_o, 1'b0);
    tick();
    respond_begin(32'h4000_0000, 5'h00);
    respond_end();
    tick();

    // Four back-to-back ADDMUL ops fill the FIFO; the fifth waits for the first pop
    for (int i = 0; i < 4; i++) begin
      do_issue(6'h20 + 6'(i), 2'd0, w);
      chk_val("b2b_no_stall", 128'(w), 128'(0));
    end
    set_issue(6'h24, 2'd0);
    issue_valid_i = 1'b1;
    @(negedge clk_i);
    chk_bit("full_stall", issue_ready_o, 1'b0);
    chk_bit("full_busy", busy_o, 1'b1);
    tick();
    respond_begin(32'h1111_0000, 5'h00);
    @(negedge clk_i);
    chk_bit("full_no_bypass", issue_ready_o, 1'b0);
    respond_end();
    do_issue(6'h24, 2'd0, w);
    chk_val("fifth_after_pop", 128'(w), 128'(0));
    for (int i = 1; i < 5; i++) begin
      respond_begin(32'h1111_0000 + 32'(i), 5'h00);
      respond_end();
    end
    tick();

    // DIVSQRT behind two ADDMUL ops stalls until both have written back
    do_issue(6'h26, 2'd0, w);
    do_issue(6'h27, 2'd0, w);
    set_issue(6'h28, 2'd1);
    issue_valid_i = 1'b1;
    @(negedge clk_i);
    chk_bit("lat_stall_two", issue_ready_o, 1'b0);
    tick();
    respond_begin(32'h2222_0026, 5'h00);
    respond_end();
    @(negedge clk_i);
    chk_bit("lat_stall_one", issue_ready_o, 1'b0);
    tick();
    respond_begin(32'h2222_0027, 5'h00);
    respond_end();
    do_issue(6'h28, 2'd1, w);
    chk_val("lat_accept_when_empty", 128'(w), 128'(0));
    respond_begin(32'h2222_0028, 5'h00);
    respond_end();
    tick();

    // Hazard against in-flight and writeback-stage destinations
    do_issue(6'h25, 2'd0, w);
    hazard_raddr_i = {6'h25, 6'h00, 6'h00};
    @(negedge clk_i);
    chk_bit("haz_inflight", hazard_o, 1'b1);
    tick();
    hazard_raddr_i = {6'h00, 6'h05, 6'h00};
    @(negedge clk_i);
    chk_bit("haz_int_alias", hazard_o, 1'b0);
    tick();
    hazard_raddr_i = {6'h00, 6'h00, 6'h25};
    respond_begin(32'h3333_0025, 5'h00);
    @(negedge clk_i);
    chk_bit("haz_rvalid_cycle", hazard_o, 1'b1);
    respond_end();
    @(negedge clk_i);
    chk_bit("haz_wb_cycle", hazard_o, 1'b1);
    tick();
    @(negedge clk_i);
    chk_bit("haz_after_wb", hazard_o, 1'b0);
    hazard_raddr_i = '0;
    tick();

    // Spurious result on an empty FIFO
    @(negedge clk_i);
    chk_bit("err_before_spurious", err_o, 1'b0);
    tick();
    respond_begin(32'hDEAD_BEEF, 5'h00);
    respond_end();
    @(negedge clk_i);
    chk_bit("spurious_no_wb", wb_valid_o, 1'b0);
    chk_bit("spurious_err", err_o, 1'b1);
    chk_bit("spurious_not_busy", busy_o, 1'b0);
    tick();

    // Sticky flags: clear, accrue, and clear coinciding with a pop
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    @(negedge clk_i);
    chk_val("fflags_cleared", 128'(fflags_o), 128'(0));
    tick();
    do_issue(6'h29, 2'd0, w);
    respond_begin(32'h4444_0029, 5'h10);
    respond_end();
    @(negedge clk_i);
    chk_val("fflags_accrue", 128'(fflags_o), 128'(5'h10));
    tick();
    do_issue(6'h2A, 2'd0, w);
    respond_begin(32'h4444_002A, 5'h04);
    fflags_clr_i = 1'b1;
    respond_end();
    fflags_clr_i = 1'b0;
    @(negedge clk_i);
    chk_val("fflags_clr_with_pop", 128'(fflags_o), 128'(5'h04));
    tick();

    // Reset mid-operation discards all state; late result flags an error
    apu_gnt_i = 1'b0;
    do_issue(6'h2B, 2'd0, w);
    @(negedge clk_i);
    chk_bit("midrst_busy_before", busy_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    exp_req.delete();
    tag_q.delete();
    #1;
    chk_bit("midrst_req", apu_req_o, 1'b0);
    chk_bit("midrst_busy", busy_o, 1'b0);
    chk_bit("midrst_err", err_o, 1'b0);
    chk_val("midrst_fflags", 128'(fflags_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    apu_gnt_i = 1'b1;
    respond_begin(32'h5555_0000, 5'h00);
    respond_end();
    @(negedge clk_i);
    chk_bit("late_result_err", err_o, 1'b1);
    chk_bit("late_result_no_wb", wb_valid_o, 1'b0);
    tick();
    tick();

    chk_val("wb_queue_drained", 128'(exp_wb.size()), 128'(0));
    chk_val("req_queue_drained", 128'(exp_req.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
